// File: rtl/rob_flush_if.sv
// rob_flush_if: allocation, completion, retire and flush signals of the reorder buffer.
interface rob_flush_if #(
    parameter int DATA_WIDTH  = 11,
    parameter int DEPTH       = 15,
    parameter int PUSH_WIDTH  = 4,
    parameter int POP_WIDTH   = 4,
    parameter int CMPLT_PORTS = 3
);
    localparam int IW  = $clog2(DEPTH);
    localparam int PRW = $clog2(PUSH_WIDTH) + 1;
    localparam int PPW = $clog2(POP_WIDTH) + 1;

    logic [DATA_WIDTH*PUSH_WIDTH-1:0] push_data;
    logic [PUSH_WIDTH-1:0]            push_valid;
    logic [PRW-1:0]                   push_ready_ct;
    logic [IW*PUSH_WIDTH-1:0]         entry_nums;
    logic [IW*CMPLT_PORTS-1:0]        cmplt_idx;
    logic [CMPLT_PORTS-1:0]           cmplt_valid;
    logic [DATA_WIDTH*POP_WIDTH-1:0]  pop_data;
    logic [PPW-1:0]                   pop_valid_ct;
    logic [PPW-1:0]                   pop_ready_ct;
    logic                             flush_valid;
    logic [IW-1:0]                    flush_idx;
    logic                             flush_all;
    logic [IW:0]                      count;
    logic                             overflow_err;

    modport master (
        output push_data, push_valid, cmplt_idx, cmplt_valid, pop_ready_ct,
               flush_valid, flush_idx, flush_all,
        input  push_ready_ct, entry_nums, pop_data, pop_valid_ct, count, overflow_err
    );

    modport slave (
        input  push_data, push_valid, cmplt_idx, cmplt_valid, pop_ready_ct,
               flush_valid, flush_idx, flush_all,
        output push_ready_ct, entry_nums, pop_data, pop_valid_ct, count, overflow_err
    );
endinterface

// File: rtl/rob_flush.sv
// rob_flush: parametrised reorder buffer with in-order multi-lane allocate and
// retire, out-of-order completion, and partial/full flush for mispredict recovery.
module rob_flush #(
    parameter int DATA_WIDTH  = 11,
    parameter int DEPTH       = 15,
    parameter int PUSH_WIDTH  = 4,
    parameter int POP_WIDTH   = 4,
    parameter int CMPLT_PORTS = 3
) (
    input logic        clk,
    input logic        rst,
    rob_flush_if.slave rob
);
    localparam int IW  = $clog2(DEPTH);
    localparam int PRW = $clog2(PUSH_WIDTH) + 1;
    localparam int PPW = $clog2(POP_WIDTH) + 1;

    logic [IW-1:0]         head_q, head_d;
    logic [IW-1:0]         tail_q, tail_d;
    logic [IW:0]           count_q, count_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  overflow_q, overflow_d;

    int   free_ct, run_ct, ret_k, keep_ct, flush_age, push_n, acc_n;
    logic run_on, thermo_ok, flush_hit;

    // Pointer add modulo DEPTH by compare/subtract, so non-power-of-two depths wrap correctly.
    function automatic logic [IW-1:0] wrap_add(input int a, input int b);
        int s;
        s = a + b;
        if (s >= DEPTH) s = s - DEPTH;
        return IW'(s);
    endfunction

    // Program-order distance of idx from head; indices beyond DEPTH map to DEPTH (never occupied).
    function automatic int age_of(input int idx, input int head);
        if (idx >= DEPTH) return DEPTH;
        if (idx >= head)  return idx - head;
        return idx + DEPTH - head;
    endfunction

    // Outputs derived purely from registered state: readiness, lane indices, retire window.
    always_comb begin
        free_ct = DEPTH - int'(count_q);
        if (free_ct > PUSH_WIDTH) free_ct = PUSH_WIDTH;
        run_ct = 0;
        run_on = 1'b1;
        for (int j = 0; j < POP_WIDTH; j++) begin
            if (run_on && j < int'(count_q) && done_q[wrap_add(int'(head_q), j)]) run_ct++;
            else run_on = 1'b0;
        end
        rob.entry_nums = '0;
        for (int i = 0; i < PUSH_WIDTH; i++)
            rob.entry_nums[i*IW +: IW] = wrap_add(int'(tail_q), i);
        rob.pop_data = '0;
        for (int j = 0; j < POP_WIDTH; j++)
            rob.pop_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[wrap_add(int'(head_q), j)];
        rob.push_ready_ct = PRW'(free_ct);
        rob.pop_valid_ct  = PPW'(run_ct);
        rob.count         = count_q;
        rob.overflow_err  = overflow_q;
    end

    // Next state: flush trims the kept range, completions and retire act inside it, push appends.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        done_d     = done_q;
        mem_d      = mem_q;
        overflow_d = overflow_q;

        ret_k = run_ct;
        if (int'(rob.pop_ready_ct) < ret_k) ret_k = int'(rob.pop_ready_ct);

        flush_age = age_of(int'(rob.flush_idx), int'(head_q));
        flush_hit = !rob.flush_all && rob.flush_valid && (flush_age < int'(count_q));
        keep_ct   = int'(count_q);
        if (rob.flush_all) keep_ct = 0;
        else if (flush_hit) keep_ct = flush_age + 1;
        // Retire never reaches past the surviving entries.
        if (ret_k > keep_ct) ret_k = keep_ct;

        for (int p = 0; p < CMPLT_PORTS; p++) begin
            if (rob.cmplt_valid[p] &&
                age_of(int'(rob.cmplt_idx[p*IW +: IW]), int'(head_q)) < keep_ct)
                done_d[rob.cmplt_idx[p*IW +: IW]] = 1'b1;
        end

        // A valid lane mask is a run of ones from lane 0: mask & (mask+1) == 0.
        push_n    = $countones(rob.push_valid);
        thermo_ok = ((rob.push_valid & (rob.push_valid + PUSH_WIDTH'(1))) == '0);
        acc_n     = 0;
        if (!rob.flush_all && !rob.flush_valid && push_n != 0) begin
            if (thermo_ok && push_n <= free_ct) acc_n = push_n;
            else overflow_d = 1'b1;
        end
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (i < acc_n) begin
                mem_d[wrap_add(int'(tail_q), i)]  = rob.push_data[i*DATA_WIDTH +: DATA_WIDTH];
                done_d[wrap_add(int'(tail_q), i)] = 1'b0;
            end
        end

        head_d = wrap_add(int'(head_q), ret_k);
        if (rob.flush_all)  tail_d = head_q;
        else if (flush_hit) tail_d = wrap_add(int'(rob.flush_idx), 1);
        else                tail_d = wrap_add(int'(tail_q), acc_n);
        count_d = (IW+1)'(keep_ct - ret_k + acc_n);
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            done_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage; contents are only observed while the entry is occupied, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_rob_flush.sv
// tb_rob_flush: directed scenarios plus randomized traffic against a queue-based ROB model.
module tb_rob_flush;
    localparam int DW    = 11;
    localparam int DEPTH = 15;
    localparam int PW    = 4;
    localparam int PO    = 4;
    localparam int CP    = 3;
    localparam int IW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_flush_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_WIDTH(PW), .POP_WIDTH(PO),
                   .CMPLT_PORTS(CP)) bus ();

    rob_flush #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_WIDTH(PW), .POP_WIDTH(PO),
                .CMPLT_PORTS(CP)) dut (.clk(clk), .rst(rst), .rob(bus));

    // Reference model: entries in program order, oldest at index 0.
    logic [DW-1:0] mdata[$];
    bit            mdone[$];
    int            m_head;
    bit            m_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cseq[3]  = '{2, 0, 1};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_run();
        int r;
        r = 0;
        for (int j = 0; j < PO && j < mdata.size(); j++) begin
            if (!mdone[j]) break;
            r++;
        end
        return r;
    endfunction

    function automatic int m_free();
        int f;
        f = DEPTH - mdata.size();
        return (f > PW) ? PW : f;
    endfunction

    task automatic check_outputs();
        int run;
        run = m_run();
        check_val("count", bus.count, mdata.size());
        check_val("push_ready_ct", bus.push_ready_ct, m_free());
        check_val("pop_valid_ct", bus.pop_valid_ct, run);
        check_val("overflow_err", bus.overflow_err, m_ovf);
        for (int i = 0; i < PW; i++)
            check_val("entry_nums", bus.entry_nums[i*IW +: IW], (m_head + mdata.size() + i) % DEPTH);
        for (int j = 0; j < run; j++)
            check_val("pop_data", bus.pop_data[j*DW +: DW], mdata[j]);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int k, keep, age, idx, n, fr;
        logic [PW-1:0] pv;
        if (!rst) begin
            mdata.delete();
            mdone.delete();
            m_head = 0;
            m_ovf  = 1'b0;
            return;
        end
        fr = m_free();
        k  = m_run();
        if (int'(bus.pop_ready_ct) < k) k = int'(bus.pop_ready_ct);
        keep = mdata.size();
        if (bus.flush_all) keep = 0;
        else if (bus.flush_valid) begin
            age = (int'(bus.flush_idx) - m_head + DEPTH) % DEPTH;
            if (int'(bus.flush_idx) < DEPTH && age < mdata.size()) keep = age + 1;
        end
        while (mdata.size() > keep) begin
            void'(mdata.pop_back());
            void'(mdone.pop_back());
        end
        if (k > keep) k = keep;
        for (int p = 0; p < CP; p++) begin
            if (bus.cmplt_valid[p]) begin
                idx = int'(bus.cmplt_idx[p*IW +: IW]);
                age = (idx - m_head + DEPTH) % DEPTH;
                if (idx < DEPTH && age < mdata.size()) mdone[age] = 1'b1;
            end
        end
        for (int r = 0; r < k; r++) begin
            void'(mdata.pop_front());
            void'(mdone.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (!bus.flush_all && !bus.flush_valid) begin
            pv = bus.push_valid;
            n  = $countones(pv);
            if (pv != PW'((1 << n) - 1) || n > fr) m_ovf = 1'b1;
            else begin
                for (int i = 0; i < n; i++) begin
                    mdata.push_back(bus.push_data[i*DW +: DW]);
                    mdone.push_back(1'b0);
                end
            end
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_data    = '0;
        bus.push_valid   = '0;
        bus.cmplt_idx    = '0;
        bus.cmplt_valid  = '0;
        bus.pop_ready_ct = '0;
        bus.flush_valid  = 1'b0;
        bus.flush_idx    = '0;
        bus.flush_all    = 1'b0;
    endtask

    task automatic push_lanes(input int n, input int base);
        bus.push_valid = PW'((1 << n) - 1);
        for (int i = 0; i < PW; i++) bus.push_data[i*DW +: DW] = DW'(base + i);
    endtask

    task automatic complete(input int port, input int idx);
        bus.cmplt_idx[port*IW +: IW] = IW'(idx);
        bus.cmplt_valid[port]        = 1'b1;
    endtask

    // Complete the oldest pending entries and retire until the buffer empties.
    task automatic drain();
        int p;
        for (int c = 0; c < 40 && mdata.size() > 0; c++) begin
            idle();
            p = 0;
            for (int a = 0; a < mdata.size() && p < CP; a++) begin
                if (!mdone[a]) begin
                    complete(p, (m_head + a) % DEPTH);
                    p++;
                end
            end
            bus.pop_ready_ct = 3'd4;
            cycle();
        end
        idle();
        check_val("drain_empty", bus.count, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        int n, r, h;
        idle();
        rst = 1'b0;
        model_step();
        @(posedge clk);
        #1;
        cycle();
        check_val("rst_count", bus.count, 0);
        check_val("rst_push_ready", bus.push_ready_ct, 4);
        check_val("rst_pop_valid", bus.pop_valid_ct, 0);
        check_val("rst_entry_lane3", bus.entry_nums[3*IW +: IW], 3);
        rst = 1'b1;

        // Fill 12 entries, then an over-capacity push is rejected.
        for (int c = 0; c < 3; c++) begin
            push_lanes(4, 'h100 + c * 4);
            cycle();
        end
        idle();
        check_val("fill_count", bus.count, 12);
        check_val("fill_ready", bus.push_ready_ct, 3);
        push_lanes(4, 'h200);
        cycle();
        idle();
        check_val("ovf_count", bus.count, 12);
        check_val("ovf_sticky", bus.overflow_err, 1);

        // Out-of-order completion of the three oldest entries, then one retire.
        for (int c = 0; c < 3; c++) begin
            idle();
            complete(0, cseq[c]);
            cycle();
        end
        idle();
        check_val("run_of_three", bus.pop_valid_ct, 3);
        check_val("head_data", bus.pop_data[DW-1:0], 'h100);
        bus.pop_ready_ct = 3'd4;
        cycle();
        idle();
        check_val("retired_count", bus.count, 9);

        // Wrap past index 14.
        push_lanes(1, 'h120);
        cycle();
        idle();
        check_val("wrap_lane0", bus.entry_nums[0*IW +: IW], 13);
        check_val("wrap_lane1", bus.entry_nums[1*IW +: IW], 14);
        check_val("wrap_lane2", bus.entry_nums[2*IW +: IW], 0);
        check_val("wrap_lane3", bus.entry_nums[3*IW +: IW], 1);
        push_lanes(4, 'h130);
        cycle();
        idle();
        check_val("wrap_count", bus.count, 14);
        drain();

        // Partial flush at idx 5 with a completion to a discarded entry and a dropped push.
        do_reset();
        push_lanes(4, 'h300); cycle();
        push_lanes(4, 'h304); cycle();
        push_lanes(2, 'h308); cycle();
        idle();
        complete(0, 3);
        cycle();
        idle();
        complete(0, 8);
        bus.flush_valid = 1'b1;
        bus.flush_idx   = 4'd5;
        push_lanes(2, 'h3f0);
        cycle();
        idle();
        check_val("pflush_count", bus.count, 6);
        check_val("pflush_tail", bus.entry_nums[0*IW +: IW], 6);
        check_val("pflush_no_ovf", bus.overflow_err, 0);
        drain();

        // Full flush while two entries are retirable: nothing retires, head stays.
        push_lanes(4, 'h400);
        cycle();
        idle();
        complete(0, m_head);
        complete(1, (m_head + 1) % DEPTH);
        cycle();
        idle();
        check_val("fall_pre_valid", bus.pop_valid_ct, 2);
        h = m_head;
        bus.flush_all    = 1'b1;
        bus.pop_ready_ct = 3'd2;
        push_lanes(1, 'h4f0);
        cycle();
        idle();
        check_val("fall_count", bus.count, 0);
        check_val("fall_head_kept", bus.entry_nums[0*IW +: IW], h);

        // Reset in the middle of activity.
        push_lanes(3, 'h500);
        cycle();
        bus.push_valid = 4'b0101;
        cycle();
        push_lanes(2, 'h510);
        complete(0, m_head);
        bus.flush_valid = 1'b1;
        bus.flush_idx   = IW'(m_head);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        idle();
        check_val("mrst_count", bus.count, 0);
        check_val("mrst_ovf", bus.overflow_err, 0);
        check_val("mrst_lane2", bus.entry_nums[2*IW +: IW], 2);

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            idle();
            r = $urandom_range(0, 99);
            n = $urandom_range(0, 4);
            bus.push_valid = PW'((1 << n) - 1);
            if (r < 3) bus.push_valid = PW'($urandom);
            for (int i = 0; i < PW; i++) bus.push_data[i*DW +: DW] = DW'($urandom);
            for (int p = 0; p < CP; p++) begin
                if ($urandom_range(0, 9) < 6) begin
                    if (mdata.size() > 0 && $urandom_range(0, 7) != 0)
                        complete(p, (m_head + $urandom_range(0, mdata.size() - 1)) % DEPTH);
                    else
                        complete(p, $urandom_range(0, 15));
                end
            end
            bus.pop_ready_ct = 3'($urandom_range(0, (r < 5) ? 7 : 4));
            bus.flush_valid  = (r >= 88 && r < 94);
            if (mdata.size() > 0 && r < 92)
                bus.flush_idx = IW'((m_head + $urandom_range(0, mdata.size() - 1)) % DEPTH);
            else
                bus.flush_idx = IW'($urandom_range(0, 15));
            bus.flush_all = (r >= 97);
            rst = (c == 250) ? 1'b0 : 1'b1;
            cycle();
        end
        rst = 1'b1;
        idle();
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
